// File: rtl/time_countdown.sv
// Hours:minutes:seconds countdown timer with load, start/pause and a done pulse at zero.
// Optional build macro TIME_COUNTDOWN_AUTORELOAD_EN: restart from the stored preset instead of expiring.
module time_countdown #(
  parameter int unsigned SECOND_REFERENCE = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] preset_seconds,
  input  logic [7:0] preset_minutes,
  input  logic [7:0] preset_hours,
  input  logic       startStop,
  output logic [7:0] seconds,
  output logic [7:0] minutes,
  output logic [7:0] hours,
  output logic       running,
  output logic       expired,
  output logic       done,
  output logic [1:0] state_dbg
);

  // Handshake: load and startStop are single-cycle pulses sampled on the rising
  // clock edge; load wins when both are high. done is a one-cycle output pulse.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, EXPIRED = 2'd3} state_t;

  localparam logic [24:0] PRESCALE_LAST = 25'(SECOND_REFERENCE - 1);

  state_t      state;
  logic [24:0] prescaler;
  logic [7:0]  clamp_s, clamp_m, clamp_h;
  logic [7:0]  dec_s, dec_m, dec_h;
  logic        tick_sec, time_zero, last_sec;
`ifdef TIME_COUNTDOWN_AUTORELOAD_EN
  logic [7:0]  store_s, store_m, store_h;
`endif

  assign state_dbg = state;

  always_comb begin
    clamp_s   = (preset_seconds > 8'd59) ? 8'd59 : preset_seconds;
    clamp_m   = (preset_minutes > 8'd59) ? 8'd59 : preset_minutes;
    clamp_h   = (preset_hours   > 8'd99) ? 8'd99 : preset_hours;
    time_zero = (seconds == 8'd0) && (minutes == 8'd0) && (hours == 8'd0);
    last_sec  = (seconds == 8'd1) && (minutes == 8'd0) && (hours == 8'd0);
    tick_sec  = (prescaler == PRESCALE_LAST);
    dec_s     = seconds;
    dec_m     = minutes;
    dec_h     = hours;
    // Borrow chain; hours is never zero here because RUN stops at 00:00:00.
    if (seconds != 8'd0) begin
      dec_s = seconds - 8'd1;
    end else if (minutes != 8'd0) begin
      dec_s = 8'd59;
      dec_m = minutes - 8'd1;
    end else begin
      dec_s = 8'd59;
      dec_m = 8'd59;
      dec_h = hours - 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      prescaler <= 25'd0;
      seconds   <= 8'd0;
      minutes   <= 8'd0;
      hours     <= 8'd0;
      running   <= 1'b0;
      expired   <= 1'b0;
      done      <= 1'b0;
`ifdef TIME_COUNTDOWN_AUTORELOAD_EN
      store_s   <= 8'd0;
      store_m   <= 8'd0;
      store_h   <= 8'd0;
`endif
    end else begin
      done <= 1'b0;
      if (load) begin
        seconds   <= clamp_s;
        minutes   <= clamp_m;
        hours     <= clamp_h;
`ifdef TIME_COUNTDOWN_AUTORELOAD_EN
        store_s   <= clamp_s;
        store_m   <= clamp_m;
        store_h   <= clamp_h;
`endif
        prescaler <= 25'd0;
        state     <= IDLE;
        running   <= 1'b0;
        expired   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (startStop && !time_zero) begin
              state     <= RUN;
              running   <= 1'b1;
              prescaler <= 25'd0;
            end
          end
          RUN: begin
            // A pause edge is still a counting cycle; expiry below overrides it.
            if (startStop) begin
              state   <= PAUSE;
              running <= 1'b0;
            end
            if (tick_sec) begin
              prescaler <= 25'd0;
              if (last_sec) begin
                done <= 1'b1;
`ifdef TIME_COUNTDOWN_AUTORELOAD_EN
                seconds <= store_s;
                minutes <= store_m;
                hours   <= store_h;
`else
                seconds <= 8'd0;
                minutes <= 8'd0;
                hours   <= 8'd0;
                state   <= EXPIRED;
                running <= 1'b0;
`endif
              end else begin
                seconds <= dec_s;
                minutes <= dec_m;
                hours   <= dec_h;
              end
            end else begin
              prescaler <= prescaler + 25'd1;
            end
          end
          PAUSE: begin
            if (startStop) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          EXPIRED: expired <= 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_time_countdown.sv
// Directed bench for time_countdown with SECOND_REFERENCE=4.
// Covers reset, countdown/expiry, borrow chain, clamping, pause, load priority and async reset.
module tb_time_countdown;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [7:0] preset_seconds = 8'd0;
  logic [7:0] preset_minutes = 8'd0;
  logic [7:0] preset_hours = 8'd0;
  logic       startStop = 1'b0;
  logic [7:0] seconds, minutes, hours;
  logic       running, expired, done;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_EXPIRED = 2'd3;

  time_countdown #(.SECOND_REFERENCE(4)) dut (
    .clock(clock), .reset(reset), .load(load),
    .preset_seconds(preset_seconds), .preset_minutes(preset_minutes),
    .preset_hours(preset_hours), .startStop(startStop),
    .seconds(seconds), .minutes(minutes), .hours(hours),
    .running(running), .expired(expired), .done(done), .state_dbg(state_dbg)
  );

  // Clock/reset block
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, ".h"}, 32'(hours), 32'(h));
    check({tag, ".m"}, 32'(minutes), 32'(m));
    check({tag, ".s"}, 32'(seconds), 32'(s));
  endtask

  task automatic check_flags(input string tag, input logic r, input logic e, input logic d,
                             input logic [1:0] st);
    check({tag, ".running"}, 32'(running), 32'(r));
    check({tag, ".expired"}, 32'(expired), 32'(e));
    check({tag, ".done"}, 32'(done), 32'(d));
    check({tag, ".state"}, 32'(state_dbg), 32'(st));
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input int h, input int m, input int s);
    preset_hours = 8'(h);
    preset_minutes = 8'(m);
    preset_seconds = 8'(s);
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic pulse_ss();
    startStop = 1'b1;
    tick();
    startStop = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    check_time("reset", 0, 0, 0);
    check_flags("reset", 1'b0, 1'b0, 1'b0, S_IDLE);
    reset = 1'b1;
    tick();

`ifndef TIME_COUNTDOWN_AUTORELOAD_EN
    // Basic countdown 00:00:02 to expiry
    do_load(0, 0, 2);
    check_time("basic_load", 0, 0, 2);
    pulse_ss();
    check_flags("basic_start", 1'b1, 1'b0, 1'b0, S_RUN);
    repeat (3) tick();
    check_time("basic_e3", 0, 0, 2);
    tick();
    check_time("basic_e4", 0, 0, 1);
    check("basic_e4.done", 32'(done), 32'd0);
    repeat (4) tick();
    check_time("basic_e8", 0, 0, 0);
    check_flags("basic_e8", 1'b0, 1'b0, 1'b1, S_EXPIRED);
    tick();
    check_flags("basic_e9", 1'b0, 1'b1, 1'b0, S_EXPIRED);
    pulse_ss();
    check_flags("expired_ss", 1'b0, 1'b1, 1'b0, S_EXPIRED);
    check_time("expired_ss", 0, 0, 0);
    do_load(0, 0, 5);
    check_flags("expired_load", 1'b0, 1'b0, 1'b0, S_IDLE);
    check_time("expired_load", 0, 0, 5);
`else
    // Auto-reload: 00:00:01 restarts every second
    do_load(0, 0, 1);
    pulse_ss();
    for (int k = 0; k < 3; k++) begin
      repeat (3) tick();
      check("reload_mid.done", 32'(done), 32'd0);
      check_time("reload_mid", 0, 0, 1);
      tick();
      check_time("reload_edge", 0, 0, 1);
      check_flags("reload_edge", 1'b1, 1'b0, 1'b1, S_RUN);
    end
`endif

    // Borrow chain
    do_load(1, 0, 0);
    pulse_ss();
    repeat (4) tick();
    check_time("borrow", 0, 59, 59);
    check("borrow.running", 32'(running), 32'd1);

    // Clamping
    do_load(200, 60, 75);
    check_time("clamp_over", 99, 59, 59);
    check_flags("clamp_over", 1'b0, 1'b0, 1'b0, S_IDLE);
    do_load(100, 0, 60);
    check_time("clamp_edge", 99, 0, 59);
    do_load(99, 59, 59);
    check_time("clamp_max", 99, 59, 59);

    // Pause: 2 RUN cycles, 20 paused, resume, decrement 2 cycles later
    do_load(0, 1, 0);
    pulse_ss();
    tick();
    pulse_ss();
    check_flags("pause", 1'b0, 1'b0, 1'b0, S_PAUSE);
    for (int k = 0; k < 20; k++) begin
      tick();
      check_time("pause_hold", 0, 1, 0);
    end
    pulse_ss();
    check_flags("resume", 1'b1, 1'b0, 1'b0, S_RUN);
    check_time("resume_r0", 0, 1, 0);
    tick();
    check_time("resume_r1", 0, 1, 0);
    tick();
    check_time("resume_r2", 0, 0, 59);

    // Load and startStop together while running
    preset_hours = 8'd0;
    preset_minutes = 8'd10;
    preset_seconds = 8'd20;
    load = 1'b1;
    startStop = 1'b1;
    tick();
    load = 1'b0;
    startStop = 1'b0;
    check_time("load_ss", 0, 10, 20);
    check_flags("load_ss", 1'b0, 1'b0, 1'b0, S_IDLE);
    repeat (6) tick();
    check_time("load_ss_idle", 0, 10, 20);

    // Asynchronous reset mid-run
    do_load(0, 5, 30);
    pulse_ss();
    repeat (2) tick();
    #2;
    reset = 1'b0;
    #1;
    check_time("async_rst", 0, 0, 0);
    check_flags("async_rst", 1'b0, 1'b0, 1'b0, S_IDLE);
    @(negedge clock);
    reset = 1'b1;
    tick();
    pulse_ss();
    check_flags("rst_ss_zero", 1'b0, 1'b0, 1'b0, S_IDLE);
    repeat (5) tick();
    check_time("rst_ss_zero", 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
